sync_fifo_core: RTL and testbench

//  Single-clock FIFO buffer, 2**P_ADDR_WIDTH entries of P_DATA_WIDTH bits.

---
 rtl/sync_fifo_core.sv | 108 ++++++++++
 tb/tb_sync_fifo_core.sv | 178 +++++++++++++++++
 2 files changed

// File: rtl/sync_fifo_core.sv
// Single-clock FIFO, 2**P_ADDR_WIDTH words of P_DATA_WIDTH bits, FWFT or registered read.
// Latency: a write at edge N is visible at edge N+1 (FWFT data_o, flags, fill level).
//          In registered mode, data_o is valid the cycle after an accepted rd_i.
// Backpressure: writes while full and reads while empty are silently dropped.
//
// Ports:
//   clk_i        clock, rising edge
//   rst_i        synchronous active-high reset (clears pointers and flags, not memory)
//   wr_i/data_i  write request and data
//   rd_i         read request / pop
//   data_o       read data (combinational head word in FWFT, registered otherwise)
//   fill_level_o number of stored words, 0..2**P_ADDR_WIDTH
//   empty_o      fill_level_o == 0
//   full_o       fill_level_o == 2**P_ADDR_WIDTH
module sync_fifo_core #(
    parameter int P_DATA_WIDTH = 8,
    parameter int P_ADDR_WIDTH = 4,
    parameter bit P_FWFT       = 1'b1
) (
    input  logic                    clk_i,
    input  logic                    rst_i,
    input  logic                    wr_i,
    input  logic [P_DATA_WIDTH-1:0] data_i,
    input  logic                    rd_i,
    output logic [P_DATA_WIDTH-1:0] data_o,
    output logic [P_ADDR_WIDTH:0]   fill_level_o,
    output logic                    empty_o,
    output logic                    full_o
);

    localparam int DEPTH = 1 << P_ADDR_WIDTH;

    // Pointers carry one extra wrap bit so that full and empty are distinguishable.
    logic [P_ADDR_WIDTH:0]   wr_ptr;
    logic [P_ADDR_WIDTH:0]   rd_ptr;
    logic [P_ADDR_WIDTH:0]   wr_ptr_nxt;
    logic [P_ADDR_WIDTH:0]   rd_ptr_nxt;
    logic [P_ADDR_WIDTH:0]   fill_nxt;
    logic                    empty_nxt;
    logic                    full_nxt;
    logic                    empty_q;
    logic                    full_q;
    logic                    wr_acc;
    logic                    rd_acc;
    logic [P_ADDR_WIDTH:0]   fill_q;

    logic [P_DATA_WIDTH-1:0] mem [DEPTH];

    // The registered flags always equal the pointer-derived flags, so they can
    // gate acceptance directly without a comparator in the accept path.
    assign wr_acc = wr_i & ~full_q;
    assign rd_acc = rd_i & ~empty_q;

    always_comb begin
        wr_ptr_nxt = wr_ptr + {{P_ADDR_WIDTH{1'b0}}, wr_acc};
        rd_ptr_nxt = rd_ptr + {{P_ADDR_WIDTH{1'b0}}, rd_acc};
        fill_nxt   = wr_ptr_nxt - rd_ptr_nxt;
        empty_nxt  = (wr_ptr_nxt == rd_ptr_nxt);
        full_nxt   = (wr_ptr_nxt[P_ADDR_WIDTH-1:0] == rd_ptr_nxt[P_ADDR_WIDTH-1:0]) &&
                     (wr_ptr_nxt[P_ADDR_WIDTH] != rd_ptr_nxt[P_ADDR_WIDTH]);
    end

    always_ff @(posedge clk_i) begin
        if (rst_i) begin
            wr_ptr  <= '0;
            rd_ptr  <= '0;
            fill_q  <= '0;
            empty_q <= 1'b1;
            full_q  <= 1'b0;
        end else begin
            wr_ptr  <= wr_ptr_nxt;
            rd_ptr  <= rd_ptr_nxt;
            fill_q  <= fill_nxt;
            empty_q <= empty_nxt;
            full_q  <= full_nxt;
        end
    end

    // Storage is deliberately not reset; stale contents are unreachable once
    // the pointers are cleared.
    always_ff @(posedge clk_i) begin
        if (!rst_i && wr_acc) begin
            mem[wr_ptr[P_ADDR_WIDTH-1:0]] <= data_i;
        end
    end

    generate
        if (P_FWFT) begin : g_fwft
            // Head word is always presented; rd_i consumes what is shown now.
            assign data_o = mem[rd_ptr[P_ADDR_WIDTH-1:0]];
        end else begin : g_reg
            logic [P_DATA_WIDTH-1:0] data_q;
            always_ff @(posedge clk_i) begin
                if (rst_i) begin
                    data_q <= '0;
                end else if (rd_acc) begin
                    data_q <= mem[rd_ptr[P_ADDR_WIDTH-1:0]];
                end
            end
            assign data_o = data_q;
        end
    endgenerate

    assign fill_level_o = fill_q;
    assign empty_o      = empty_q;
    assign full_o       = full_q;

endmodule

// File: tb/tb_sync_fifo_core.sv
module tb_sync_fifo_core;

    logic       clk;
    logic       rst;
    logic       wr_f, rd_f, wr_r, rd_r;
    logic [7:0] din_f, din_r, dout_f, dout_r;
    logic [4:0] fill_f, fill_r;
    logic       empty_f, full_f, empty_r, full_r;

    int total = 0;
    int bad   = 0;

    // Reference model: plain queues of accepted words, capacity 16.
    logic [7:0] qf[$];
    logic [7:0] qr[$];
    logic [7:0] exp_r;
    int         n_rd_f;
    int         n_rd_r;

    sync_fifo_core #(.P_DATA_WIDTH(8), .P_ADDR_WIDTH(4), .P_FWFT(1'b1)) u_fwft (
        .clk_i(clk), .rst_i(rst), .wr_i(wr_f), .data_i(din_f), .rd_i(rd_f),
        .data_o(dout_f), .fill_level_o(fill_f), .empty_o(empty_f), .full_o(full_f)
    );

    sync_fifo_core #(.P_DATA_WIDTH(8), .P_ADDR_WIDTH(4), .P_FWFT(1'b0)) u_reg (
        .clk_i(clk), .rst_i(rst), .wr_i(wr_r), .data_i(din_r), .rd_i(rd_r),
        .data_o(dout_r), .fill_level_o(fill_r), .empty_o(empty_r), .full_o(full_r)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic chk_f_state();
        chk("fwft_fill",  32'(fill_f),  32'(qf.size()));
        chk("fwft_empty", 32'(empty_f), 32'(qf.size() == 0));
        chk("fwft_full",  32'(full_f),  32'(qf.size() == 16));
        if (qf.size() != 0) chk("fwft_head", 32'(dout_f), 32'(qf[0]));
    endtask

    task automatic chk_r_state();
        chk("reg_fill",  32'(fill_r),  32'(qr.size()));
        chk("reg_empty", 32'(empty_r), 32'(qr.size() == 0));
        chk("reg_full",  32'(full_r),  32'(qr.size() == 16));
        chk("reg_data",  32'(dout_r),  32'(exp_r));
    endtask

    // One clock of FWFT stimulus; called just after a falling edge.
    task automatic cyc_f(input bit w, input logic [7:0] d, input bit r);
        bit ra, wa;
        wr_f = w; din_f = d; rd_f = r;
        ra = r && (qf.size() != 0);
        wa = w && (qf.size() != 16);
        if (ra) chk("fwft_pop_dat", 32'(dout_f), 32'(qf[0]));
        if (r && !empty_f) n_rd_f++;
        @(posedge clk);
        if (ra) void'(qf.pop_front());
        if (wa) qf.push_back(d);
        @(negedge clk);
        wr_f = 1'b0; rd_f = 1'b0;
        chk_f_state();
    endtask

    task automatic cyc_r(input bit w, input logic [7:0] d, input bit r);
        bit ra, wa;
        wr_r = w; din_r = d; rd_r = r;
        ra = r && (qr.size() != 0);
        wa = w && (qr.size() != 16);
        if (r && !empty_r) n_rd_r++;
        @(posedge clk);
        if (ra) exp_r = qr.pop_front();
        if (wa) qr.push_back(d);
        @(negedge clk);
        wr_r = 1'b0; rd_r = 1'b0;
        chk_r_state();
    endtask

    task automatic do_reset();
        rst = 1'b1;
        wr_f = 1'b0; rd_f = 1'b0; wr_r = 1'b0; rd_r = 1'b0;
        repeat (2) @(posedge clk);
        qf.delete(); qr.delete(); exp_r = 8'h00;
        @(negedge clk);
        rst = 1'b0;
        chk_f_state();
        chk_r_state();
    endtask

    initial begin
        int w;
        int free;
        int n;
        rst = 1'b1; wr_f = 0; rd_f = 0; wr_r = 0; rd_r = 0;
        din_f = 8'h00; din_r = 8'h00; exp_r = 8'h00;
        n_rd_f = 0; n_rd_r = 0;
        @(negedge clk);

        // 1. reset, then reads on empty change nothing
        do_reset();
        cyc_f(0, 8'h00, 1);
        cyc_r(0, 8'h00, 1);
        // read while empty with simultaneous write: only the write lands
        cyc_f(1, 8'h3C, 1);
        chk("empty_rdwr_fill", 32'(fill_f), 32'd1);
        cyc_f(0, 8'h00, 1);

        // 2. FWFT streaming burst, rd = ~empty
        n_rd_f = 0; w = 0;
        for (int c = 0; c < 200 && (w < 10 || qf.size() != 0); c++) begin
            cyc_f(w < 10, 8'($urandom), qf.size() != 0);
            if (w < 10) w++;
        end
        chk("fwft_rd_total", 32'(n_rd_f), 32'd10);

        // 3. fill to 16, then a dropped write, then a dropped write alongside a read
        for (int i = 0; i < 16; i++) begin
            cyc_f(1, 8'($urandom), 0);
            chk("fill_step", 32'(fill_f), 32'(i + 1));
        end
        chk("full_at_16", 32'(full_f), 32'd1);
        cyc_f(1, 8'hAA, 0);
        chk("drop_fill", 32'(fill_f), 32'd16);
        cyc_f(1, 8'h55, 1);
        chk("drop_rd_fill", 32'(fill_f), 32'd15);

        // 4. drain, then traffic across the pointer wrap
        for (int c = 0; c < 40 && qf.size() != 0; c++) cyc_f(0, 8'h00, 1);
        chk("drained_empty", 32'(empty_f), 32'd1);
        chk("drained_fill",  32'(fill_f),  32'd0);
        for (int i = 0; i < 20; i++) begin
            cyc_f(1, 8'($urandom), 0);
            cyc_f(0, 8'h00, 1);
        end

        // 5. simultaneous read+write at fill 5
        for (int i = 0; i < 5; i++) cyc_f(1, 8'($urandom), 0);
        for (int i = 0; i < 8; i++) begin
            cyc_f(1, 8'($urandom), 1);
            chk("simul_fill", 32'(fill_f), 32'd5);
        end
        // reset with data present discards everything
        do_reset();
        chk("midrst_empty", 32'(empty_f), 32'd1);
        cyc_f(1, 8'hC3, 0);
        chk("post_rst_head", 32'(dout_f), 32'hC3);
        cyc_f(0, 8'h00, 1);

        // 6. registered-read mode: streaming burst, then random bursts
        n_rd_r = 0; w = 0;
        for (int c = 0; c < 200 && (w < 10 || qr.size() != 0); c++) begin
            cyc_r(w < 10, 8'($urandom), qr.size() != 0);
            if (w < 10) w++;
        end
        chk("reg_rd_total", 32'(n_rd_r), 32'd10);
        for (int b = 0; b < 100; b++) begin
            free = 16 - qr.size();
            if (free == 0) begin
                cyc_r(0, 8'h00, 1);
                free = 1;
            end
            n = $urandom_range(free, 1);
            for (int k = 0; k < n; k++) cyc_r(1, 8'($urandom), 1'($urandom_range(1, 0)));
        end
        for (int c = 0; c < 40 && qr.size() != 0; c++) cyc_r(0, 8'h00, 1);
        chk("reg_final_empty", 32'(empty_r), 32'd1);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
